// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file (package proc_pkg).
package proc_pkg;
  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [WIDTH-1:0]  word_t;

  localparam reg_idx_t ZERO_REG = '0;

  // One bit of the write decode; a low enable forces 0 even when idx is unknown.
  function automatic logic wr_hit(input logic en, input reg_idx_t wr_idx, input reg_idx_t idx);
    wr_hit = en && (wr_idx == idx);
  endfunction
endpackage

// File: rtl/regfile_if.sv
// Write and read-port bundle of the register file; master drives indices/data, slave returns reads.
interface regfile_if;
  import proc_pkg::*;

  logic     ctrl_writeEnable;
  reg_idx_t ctrl_writeReg;
  word_t    data_writeReg;
  reg_idx_t ctrl_readRegA;
  reg_idx_t ctrl_readRegB;
  word_t    data_readRegA;
  word_t    data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/regfile_register_32.sv
// One architectural register: async active-high clear, load on enable.
module register_32
  import proc_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  i_en,
  input  word_t i_d,
  output word_t o_q
);
  word_t r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/regfile.sv
// 32 x WIDTH register file: one synchronous write port, two combinational read ports, r0 reads 0.
// Optional write-first forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile
  import proc_pkg::*;
(
  input logic       clock,
  input logic       reset,
  regfile_if.slave  bus
);
  word_t w_regs [NUM_REGS];

  // r0 has no storage; only indices 1..31 get a register and a decode bit.
  assign w_regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic w_we;
    assign w_we = wr_hit(bus.ctrl_writeEnable, bus.ctrl_writeReg, reg_idx_t'(g));

    register_32 u_reg (
      .clock (clock),
      .reset (reset),
      .i_en  (w_we),
      .i_d   (bus.data_writeReg),
      .o_q   (w_regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_ok, w_fwd_a, w_fwd_b;

  // Forwarding is held off during reset so the ports keep reading the cleared state.
  assign w_fwd_ok = !reset && bus.ctrl_writeEnable && (bus.ctrl_writeReg != ZERO_REG);
  assign w_fwd_a  = w_fwd_ok && (bus.ctrl_readRegA == bus.ctrl_writeReg);
  assign w_fwd_b  = w_fwd_ok && (bus.ctrl_readRegB == bus.ctrl_writeReg);

  assign bus.data_readRegA = w_fwd_a ? bus.data_writeReg : w_regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = w_fwd_b ? bus.data_writeReg : w_regs[bus.ctrl_readRegB];
`else
  assign bus.data_readRegA = w_regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = w_regs[bus.ctrl_readRegB];
`endif
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: array model compared every cycle plus hand-computed literal checks.
module tb_regfile;
  import proc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  regfile_if bus ();

  regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int    n_cmp = 0;
  int    n_err = 0;
  logic  chk_en = 1'b0;
  word_t model [NUM_REGS];

  // Architectural model: array of 32 words, r0 never written.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (bus.ctrl_writeEnable === 1'b1 && bus.ctrl_writeReg != ZERO_REG) begin
      model[bus.ctrl_writeReg] = bus.data_writeReg;
    end
  end

  function automatic word_t exp_rd(input reg_idx_t idx);
`ifdef REGFILE_BYPASS_EN
    if (!reset && bus.ctrl_writeEnable === 1'b1 && bus.ctrl_writeReg != ZERO_REG &&
        bus.ctrl_writeReg == idx)
      return bus.data_writeReg;
`endif
    return (idx == ZERO_REG) ? word_t'(0) : model[idx];
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_A", bus.data_readRegA, exp_rd(bus.ctrl_readRegA));
      check("model_B", bus.data_readRegB, exp_rd(bus.ctrl_readRegB));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.ctrl_readRegA = reg_idx_t'(i);
      bus.ctrl_readRegB = reg_idx_t'(NUM_REGS - 1 - i);
      #1;
      check(name, bus.data_readRegA, 32'h0);
      check(name, bus.data_readRegB, 32'h0);
      step();
    end
  endtask

  initial begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_readRegA    = '0;
    bus.ctrl_readRegB    = '0;
    repeat (2) step();
    reset  = 1'b0;
    chk_en = 1'b1;

    sweep_zero("reset_state");

    // Write r7, read it on both ports the next cycle; neighbours untouched.
    bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd7; bus.data_writeReg = 32'h12345678;
    step();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_readRegA = 5'd7; bus.ctrl_readRegB = 5'd7; #1;
    check("r7_A", bus.data_readRegA, 32'h12345678);
    check("r7_B", bus.data_readRegB, 32'h12345678);
    bus.ctrl_readRegA = 5'd6; bus.ctrl_readRegB = 5'd8; #1;
    check("r6", bus.data_readRegA, 32'h0);
    check("r8", bus.data_readRegB, 32'h0);
    step();

    // r0 write is discarded and never forwarded.
    bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd0; bus.data_writeReg = 32'hFFFFFFFF;
    bus.ctrl_readRegA = 5'd0; bus.ctrl_readRegB = 5'd0; #1;
    check("r0_same_A", bus.data_readRegA, 32'h0);
    check("r0_same_B", bus.data_readRegB, 32'h0);
    step();
    bus.ctrl_writeEnable = 1'b0; #1;
    check("r0_after_A", bus.data_readRegA, 32'h0);
    check("r0_after_B", bus.data_readRegB, 32'h0);

    // Disabled write and unknown write index leave state alone.
    bus.ctrl_writeReg = 5'd3; bus.data_writeReg = 32'hAAAA5555;
    step();
    bus.ctrl_writeReg = 'x; bus.data_writeReg = 32'h5A5A5A5A;
    step();
    bus.ctrl_writeReg = 5'd0;
    bus.ctrl_readRegA = 5'd3; bus.ctrl_readRegB = 5'd7; #1;
    check("gate_r3", bus.data_readRegA, 32'h0);
    check("gate_r7", bus.data_readRegB, 32'h12345678);
    step();

    // Same-cycle read of the write target.
    bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd9; bus.data_writeReg = 32'h0000BEEF;
    bus.ctrl_readRegA = 5'd9; bus.ctrl_readRegB = 5'd8; #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_same", bus.data_readRegA, 32'h0000BEEF);
`else
    check("r9_same", bus.data_readRegA, 32'h0);
`endif
    check("r9_other", bus.data_readRegB, 32'h0);
    step();
    bus.ctrl_writeEnable = 1'b0; #1;
    check("r9_after", bus.data_readRegA, 32'h0000BEEF);

    // Async reset mid-run clears r5 without a clock edge; a write under reset is lost.
    bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd5; bus.data_writeReg = 32'hDEADBEEF;
    step();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_readRegA = 5'd5; bus.ctrl_readRegB = 5'd9; #1;
    check("r5_written", bus.data_readRegA, 32'hDEADBEEF);
    reset = 1'b1; #1;
    check("r5_async_clr", bus.data_readRegA, 32'h0);
    check("r9_async_clr", bus.data_readRegB, 32'h0);
    step();
    bus.ctrl_writeEnable = 1'b1; bus.data_writeReg = 32'h11111111; #1;
    check("rst_fwd_off", bus.data_readRegA, 32'h0);
    step();
    bus.ctrl_writeEnable = 1'b0;
    reset = 1'b0;
    step();
    sweep_zero("post_reset");

    // Fill every register with a distinct pattern, then read crossed pairs.
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = reg_idx_t'(i);
      bus.data_writeReg    = word_t'(i) * 32'h01010101;
      step();
    end
    bus.ctrl_writeEnable = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.ctrl_readRegA = reg_idx_t'(i);
      bus.ctrl_readRegB = reg_idx_t'(NUM_REGS - 1 - i);
      #1;
      check("sweep_A", bus.data_readRegA, word_t'(i) * 32'h01010101);
      check("sweep_B", bus.data_readRegB, word_t'(NUM_REGS - 1 - i) * 32'h01010101);
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
